// File: rtl/mul_accumulate_stage.sv
// Multiply-accumulate sequencer: feeds operand pairs to an external combinational
// multiplier and sums the returned products into a guarded, overflow-tracking accumulator.
module mul_accumulate_stage #(
    parameter int SIZE      = 16,
    parameter int ACC_GUARD = 8,
    parameter int LEN_WIDTH = 8
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        Start,
    input  logic [LEN_WIDTH-1:0]        Length,
    input  logic                        InValid,
    input  logic [SIZE-1:0]             InA,
    input  logic [SIZE-1:0]             InB,
    output logic                        InReady,
    output logic [SIZE-1:0]             MulA,
    output logic [SIZE-1:0]             MulB,
    input  logic [2*SIZE-1:0]           Product,
    output logic                        OutValid,
    output logic [2*SIZE+ACC_GUARD-1:0] OutAcc,
    input  logic                        OutReady,
    output logic                        Overflow,
    output logic                        Busy
);

    localparam int ACC_W = 2 * SIZE + ACC_GUARD;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]           r_state;
    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH-1:0] r_cnt;
    logic [SIZE-1:0]      r_mul_a;
    logic [SIZE-1:0]      r_mul_b;
    logic                 r_pipe_valid;
    logic [ACC_W-1:0]     r_acc;
    logic                 r_ovf;

    logic                 w_accept;
    logic                 w_last;
    logic [ACC_W:0]       w_sum;

    assign w_accept = InValid && (r_state == S_RUN);
    assign w_last   = (r_cnt == (r_len - LEN_WIDTH'(1)));
    // One extra bit on the sum exposes the accumulator carry-out.
    assign w_sum    = {1'b0, r_acc} + {{(ACC_GUARD + 1){1'b0}}, Product};

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_cnt        <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_pipe_valid <= 1'b0;
            r_acc        <= '0;
            r_ovf        <= 1'b0;
        end else begin
            if (r_pipe_valid) begin
                r_acc <= w_sum[ACC_W-1:0];
                if (w_sum[ACC_W]) r_ovf <= 1'b1;
            end
            r_pipe_valid <= w_accept;
            if (w_accept) begin
                r_mul_a <= InA;
                r_mul_b <= InB;
                r_cnt   <= r_cnt + LEN_WIDTH'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_len   <= Length;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                        r_state <= (Length != '0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    if (w_accept && w_last) r_state <= S_DRAIN;
                end
                S_DRAIN: r_state <= S_DONE;
                S_DONE: begin
                    if (OutReady) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign InReady  = (r_state == S_RUN);
    assign OutValid = (r_state == S_DONE);
    assign Busy     = (r_state != S_IDLE);
    assign MulA     = r_mul_a;
    assign MulB     = r_mul_b;
    assign OutAcc   = r_acc;
    assign Overflow = r_ovf;

endmodule

// File: tb/tb_mul_accumulate_stage.sv
// Directed bench for mul_accumulate_stage: a default instance plus an ACC_GUARD=1 instance
// share stimulus; expected results are queued at Start and popped when OutValid appears.
module tb_mul_accumulate_stage;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic [7:0]  Length;
    logic        InValid;
    logic [15:0] InA;
    logic [15:0] InB;
    logic        OutReady;

    logic        InReady,  InReady_g;
    logic [15:0] MulA,     MulB,     MulA_g, MulB_g;
    logic [31:0] Product,  Product_g;
    logic        OutValid, OutValid_g;
    logic [39:0] OutAcc;
    logic [32:0] OutAcc_g;
    logic        Overflow, Overflow_g;
    logic        Busy,     Busy_g;

    assign Product   = MulA * MulB;
    assign Product_g = MulA_g * MulB_g;

    mul_accumulate_stage dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Length(Length),
        .InValid(InValid), .InA(InA), .InB(InB), .InReady(InReady),
        .MulA(MulA), .MulB(MulB), .Product(Product), .OutValid(OutValid),
        .OutAcc(OutAcc), .OutReady(OutReady), .Overflow(Overflow), .Busy(Busy)
    );

    mul_accumulate_stage #(.ACC_GUARD(1)) dut_g (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Length(Length),
        .InValid(InValid), .InA(InA), .InB(InB), .InReady(InReady_g),
        .MulA(MulA_g), .MulB(MulB_g), .Product(Product_g), .OutValid(OutValid_g),
        .OutAcc(OutAcc_g), .OutReady(OutReady), .Overflow(Overflow_g), .Busy(Busy_g)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        longint unsigned acc;
        logic            ovf;
    } exp_t;

    exp_t            sb[$];
    exp_t            sb_g[$];
    int unsigned     pa[$];
    int unsigned     pb[$];
    int              checks   = 0;
    int              failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference sum of pa[i]*pb[i] modulo 2^(32+guard), with sticky carry-out.
    function automatic exp_t model(input int guard);
        exp_t            e;
        longint unsigned s;
        longint unsigned mask;
        mask  = (64'd1 << (32 + guard)) - 64'd1;
        e.acc = 0;
        e.ovf = 1'b0;
        for (int i = 0; i < pa.size(); i++) begin
            s = e.acc + longint'(pa[i]) * longint'(pb[i]);
            if ((s & ~mask) != 0) e.ovf = 1'b1;
            e.acc = s & mask;
        end
        return e;
    endfunction

    task automatic do_run(input string name, input int len, input int gap, input int hold);
        exp_t            e;
        exp_t            eg;
        longint unsigned partial;
        int              t;
        int              waited;
        sb.push_back(model(8));
        sb_g.push_back(model(1));
        partial = 0;

        @(negedge Clock);
        Start  = 1'b1;
        Length = 8'(len);
        @(posedge Clock);
        #1;
        t     = cyc;
        Start = 1'b0;
        @(negedge Clock);

        for (int i = 0; i < len; i++) begin
            if (i > 0) begin
                InValid = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    @(posedge Clock);
                    @(negedge Clock);
                    check({name, "_gap_acc"}, OutAcc, partial);
                end
            end
            InValid = 1'b1;
            InA     = 16'(pa[i]);
            InB     = 16'(pb[i]);
            waited  = 0;
            while (!InReady && waited < 20) begin
                @(negedge Clock);
                waited++;
            end
            check({name, "_in_ready"}, InReady, 1);
            @(posedge Clock);
            @(negedge Clock);
            partial = (partial + longint'(pa[i]) * longint'(pb[i])) & 64'hFF_FFFF_FFFF;
        end
        InValid = 1'b0;

        waited = 0;
        while (!OutValid && waited < 20) begin
            check({name, "_in_ready_low"}, InReady, 0);
            @(negedge Clock);
            waited++;
        end
        check({name, "_out_valid"}, OutValid, 1);
        if (gap == 0) check({name, "_latency"}, 64'(cyc), 64'((len == 0) ? t : t + len + 1));

        e  = sb.pop_front();
        eg = sb_g.pop_front();
        check({name, "_acc"}, OutAcc, e.acc);
        check({name, "_ovf"}, Overflow, e.ovf);
        check({name, "_acc_g"}, OutAcc_g, eg.acc);
        check({name, "_ovf_g"}, Overflow_g, eg.ovf);
        check({name, "_done_in_ready"}, InReady, 0);
        check({name, "_done_busy"}, Busy, 1);

        for (int h = 0; h < hold; h++) begin
            Start  = (h == 1 || h == 3);
            Length = 8'd5;
            @(posedge Clock);
            @(negedge Clock);
            check({name, "_hold_valid"}, OutValid, 1);
            check({name, "_hold_acc"}, OutAcc, e.acc);
            check({name, "_hold_ovf"}, Overflow, e.ovf);
        end
        Start    = 1'b0;
        OutReady = 1'b1;
        @(posedge Clock);
        #1;
        check({name, "_release_valid"}, OutValid, 0);
        check({name, "_release_busy"}, Busy, 0);
        OutReady = 1'b0;
        @(negedge Clock);
        check({name, "_idle_stays"}, Busy, 0);
    endtask

    initial begin
        Reset    = 1'b1;
        Start    = 1'b0;
        Length   = '0;
        InValid  = 1'b0;
        InA      = '0;
        InB      = '0;
        OutReady = 1'b0;
        #12;
        check("rst_in_ready", InReady, 0);
        check("rst_out_valid", OutValid, 0);
        check("rst_busy", Busy, 0);
        check("rst_acc", OutAcc, 0);
        check("rst_mul_a", MulA, 0);
        check("rst_ovf", Overflow, 0);
        @(negedge Clock);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        check("post_rst_idle", Busy, 0);

        pa = '{2, 4, 65535};
        pb = '{3, 5, 65535};
        do_run("len3", 3, 0, 0);

        pa = {};
        pb = {};
        do_run("len0", 0, 0, 0);

        pa = '{7, 10};
        pb = '{9, 10};
        do_run("gap", 2, 3, 0);

        pa = '{65535, 65535, 65535};
        pb = '{65535, 65535, 65535};
        do_run("guard", 3, 0, 0);

        pa = '{100, 3};
        pb = '{200, 4};
        do_run("hold", 2, 0, 5);

        // Interrupted run: two of four pairs accepted, then reset mid-cycle.
        @(negedge Clock);
        Start  = 1'b1;
        Length = 8'd4;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        @(negedge Clock);
        for (int i = 0; i < 2; i++) begin
            InValid = 1'b1;
            InA     = 16'(1000 * (i + 1));
            InB     = 16'(1000 * (i + 1));
            check("irq_in_ready", InReady, 1);
            @(posedge Clock);
            @(negedge Clock);
        end
        InValid = 1'b0;
        #1;
        Reset = 1'b1;
        #1;
        check("mid_rst_busy", Busy, 0);
        check("mid_rst_in_ready", InReady, 0);
        check("mid_rst_out_valid", OutValid, 0);
        check("mid_rst_acc", OutAcc, 0);
        check("mid_rst_mul_a", MulA, 0);
        check("mid_rst_mul_b", MulB, 0);
        check("mid_rst_ovf", Overflow, 0);
        @(negedge Clock);
        Reset = 1'b0;
        repeat (3) begin
            @(negedge Clock);
            check("after_rst_busy", Busy, 0);
            check("after_rst_acc", OutAcc, 0);
        end

        pa = '{3};
        pb = '{3};
        do_run("len1", 1, 0, 0);

        check("sb_empty", 64'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
